// File: rtl/v2_pulse_analyzer_pkg.sv
// Shared constants, FSM state type and result record for the v2 pulse-height analyzer.
package v2_param;

    localparam int V2_WIDTH     = 16;
    localparam int V2_THR       = 100;
    localparam int V2_HOLDOFF   = 4;
    localparam int V2_MAX_WIDTH = 20;
    localparam int V2_TS_WIDTH  = 32;
    localparam int V2_PW_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        HOLD
    } v2_pa_state_t;

    // "time" is a reserved word, so the timestamp field is called stamp.
    typedef struct packed {
        logic [V2_WIDTH-1:0]    amp;
        logic [V2_TS_WIDTH-1:0] stamp;
        logic [V2_PW_WIDTH-1:0] width;
        logic                   pileup;
    } v2_peak_t;

endpackage

// File: rtl/v2_pulse_analyzer_result_reg.sv
// One-entry valid/ready result holding register; a result arriving while full and stalled is dropped.
module v2_result_reg
    import v2_param::*;
#(
    parameter type peak_t = v2_peak_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  emit,
    input  peak_t emit_data,
    input  logic  peak_ready,
    output logic  peak_valid,
    output peak_t peak,
    output logic  overflow
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_valid <= 1'b0;
            peak       <= '0;
            overflow   <= 1'b0;
        end else begin
            if (emit && (!peak_valid || peak_ready)) begin
                peak       <= emit_data;
                peak_valid <= 1'b1;
            end else if (emit) begin
                overflow   <= 1'b1;
            end else if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/v2_pulse_analyzer.sv
// Threshold-triggered pulse analyzer: tracks peak amplitude/time, time-over-threshold and pile-up per pulse.
module v2_pulse_analyzer #(
    parameter int V2_WIDTH     = v2_param::V2_WIDTH,
    parameter int V2_THR       = v2_param::V2_THR,
    parameter int V2_HOLDOFF   = v2_param::V2_HOLDOFF,
    parameter int V2_MAX_WIDTH = v2_param::V2_MAX_WIDTH,
    parameter int V2_TS_WIDTH  = v2_param::V2_TS_WIDTH,
    parameter int V2_PW_WIDTH  = v2_param::V2_PW_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [V2_WIDTH-1:0]    input_data,
    input  logic                   peak_ready,
    output logic                   peak_valid,
    output logic [V2_WIDTH-1:0]    peak_amp,
    output logic [V2_TS_WIDTH-1:0] peak_time,
    output logic [V2_PW_WIDTH-1:0] peak_width,
    output logic                   peak_pileup,
    output logic                   overflow,
    output logic                   busy
);
    import v2_param::v2_pa_state_t;
    import v2_param::IDLE;
    import v2_param::RISE;
    import v2_param::HOLD;

    // Same layout as v2_param::v2_peak_t, but following this instance's widths.
    typedef struct packed {
        logic [V2_WIDTH-1:0]    amp;
        logic [V2_TS_WIDTH-1:0] stamp;
        logic [V2_PW_WIDTH-1:0] width;
        logic                   pileup;
    } peak_t;

    localparam int PILE_W = $clog2(V2_MAX_WIDTH + 2);
    localparam logic [PILE_W-1:0]      PILE_SAT  = PILE_W'(V2_MAX_WIDTH + 1);
    localparam logic [PILE_W-1:0]      PILE_MAX  = PILE_W'(V2_MAX_WIDTH);
    localparam logic signed [V2_WIDTH-1:0] THR_S = V2_WIDTH'(V2_THR);
    localparam logic [7:0]             HOLD_LOAD = (V2_HOLDOFF == 0) ? 8'd0 : 8'(V2_HOLDOFF - 1);

    v2_pa_state_t state, state_nx;

    logic signed [V2_WIDTH-1:0] sample;
    logic signed [V2_WIDTH-1:0] max_amp;
    logic [V2_TS_WIDTH-1:0]     ts;
    logic [V2_TS_WIDTH-1:0]     tmax;
    logic [V2_PW_WIDTH-1:0]     pw_cnt;
    logic [PILE_W-1:0]          pile_cnt;
    logic [7:0]                 hold_cnt;
    logic                       above;
    logic                       start;
    logic                       extend;
    logic                       emit;
    peak_t                      emit_data;
    peak_t                      peak;

    assign sample = $signed(input_data);
    assign above  = sample > THR_S;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        extend   = 1'b0;
        emit     = 1'b0;
        case (state)
            IDLE: begin
                if (above) begin
                    state_nx = RISE;
                    start    = 1'b1;
                end
            end
            RISE: begin
                if (above) begin
                    extend = 1'b1;
                end else begin
                    emit     = 1'b1;
                    state_nx = (V2_HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == 8'd0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts       <= '0;
            max_amp  <= '0;
            tmax     <= '0;
            pw_cnt   <= '0;
            pile_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            ts <= ts + V2_TS_WIDTH'(1);
            if (start) begin
                max_amp  <= sample;
                tmax     <= ts;
                pw_cnt   <= V2_PW_WIDTH'(1);
                pile_cnt <= PILE_W'(1);
            end
            if (extend) begin
                if (pw_cnt != '1)         pw_cnt   <= pw_cnt + V2_PW_WIDTH'(1);
                if (pile_cnt != PILE_SAT) pile_cnt <= pile_cnt + PILE_W'(1);
                // Strict compare: on a tie the earlier timestamp is kept.
                if (sample > max_amp) begin
                    max_amp <= sample;
                    tmax    <= ts;
                end
            end
            if (emit)                                       hold_cnt <= HOLD_LOAD;
            else if (state == HOLD && hold_cnt != 8'd0)     hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign emit_data = '{amp:    max_amp,
                         stamp:  tmax,
                         width:  pw_cnt,
                         pileup: (pile_cnt > PILE_MAX)};

    v2_result_reg #(
        .peak_t (peak_t)
    ) u_result_reg (
        .clk        (clk),
        .reset      (reset),
        .emit       (emit),
        .emit_data  (emit_data),
        .peak_ready (peak_ready),
        .peak_valid (peak_valid),
        .peak       (peak),
        .overflow   (overflow)
    );

    assign peak_amp    = peak.amp;
    assign peak_time   = peak.stamp;
    assign peak_width  = peak.width;
    assign peak_pileup = peak.pileup;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_v2_pulse_analyzer.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop and compare on each transfer.
module tb_v2_pulse_analyzer;

    localparam int W  = 16;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  input_data;
    logic          peak_ready;

    logic          peak_valid,  peak_pileup,  overflow,  busy;
    logic [W-1:0]  peak_amp;
    logic [TW-1:0] peak_time;
    logic [7:0]    peak_width;

    logic          peak_valid4, peak_pileup4, overflow4, busy4;
    logic [W-1:0]  peak_amp4;
    logic [TW-1:0] peak_time4;
    logic [3:0]    peak_width4;

    typedef struct {
        int amp;
        int t;
        int w;
        int p;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    v2_pulse_analyzer dut (
        .clk(clk), .reset(reset), .input_data(input_data), .peak_ready(peak_ready),
        .peak_valid(peak_valid), .peak_amp(peak_amp), .peak_time(peak_time),
        .peak_width(peak_width), .peak_pileup(peak_pileup), .overflow(overflow), .busy(busy)
    );

    v2_pulse_analyzer #(.V2_PW_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .input_data(input_data), .peak_ready(peak_ready),
        .peak_valid(peak_valid4), .peak_amp(peak_amp4), .peak_time(peak_time4),
        .peak_width(peak_width4), .peak_pileup(peak_pileup4), .overflow(overflow4), .busy(busy4)
    );

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void push_exp(input int amp, input int t, input int w, input int p);
        exp_t e;
        e.amp = amp; e.t = t; e.w = w; e.p = p;
        q8.push_back(e);
        e.w = (w > 15) ? 15 : w;
        q4.push_back(e);
    endfunction

    task automatic drive(input int v);
        input_data = W'(v);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && peak_valid && peak_ready) begin
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: amp %0d time %0d width %0d", $signed(peak_amp), peak_time, peak_width);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if ($signed(peak_amp) != e.amp || peak_time != TW'(e.t) || int'(peak_width) != e.w || int'(peak_pileup) != e.p) begin
                    fails++;
                    $display("FAIL result: got amp %0d time %0d width %0d pileup %0d expected amp %0d time %0d width %0d pileup %0d",
                             $signed(peak_amp), peak_time, peak_width, peak_pileup, e.amp, e.t, e.w, e.p);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && peak_valid4 && peak_ready) begin
            tests++;
            if (q4.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result_pw4: amp %0d width %0d", $signed(peak_amp4), peak_width4);
            end else begin
                exp_t e;
                e = q4.pop_front();
                if ($signed(peak_amp4) != e.amp || peak_time4 != TW'(e.t) || int'(peak_width4) != e.w || int'(peak_pileup4) != e.p) begin
                    fails++;
                    $display("FAIL result_pw4: got amp %0d time %0d width %0d pileup %0d expected amp %0d time %0d width %0d pileup %0d",
                             $signed(peak_amp4), peak_time4, peak_width4, peak_pileup4, e.amp, e.t, e.w, e.p);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        input_data = '0;
        peak_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid",    peak_valid, 0);
        check("reset_amp",      peak_amp, 0);
        check("reset_time",     peak_time, 0);
        check("reset_width",    peak_width, 0);
        check("reset_pileup",   peak_pileup, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy",     busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // ts 0..13: basic pulse
        for (int i = 0; i < 9; i++) drive(0);
        drive(50);
        drive(150);
        check("busy_rise", busy, 1);
        drive(300);
        drive(250);
        push_exp(300, 11, 3, 0);
        drive(90);
        for (int i = 14; i < 20; i++) drive(0);

        // ts 20..23: tie keeps the earlier timestamp
        drive(120);
        drive(200);
        drive(200);
        push_exp(200, 21, 3, 0);
        drive(80);
        for (int i = 24; i < 29; i++) drive(0);

        // ts 29..36: hold-off window
        drive(200);
        push_exp(200, 29, 1, 0);
        drive(50);
        drive(0);
        drive(500);
        check("busy_hold_32", busy, 1);
        drive(0);
        check("busy_hold_33", busy, 1);
        drive(0);
        check("busy_idle_34", busy, 0);
        drive(500);
        check("busy_restart_35", busy, 1);
        push_exp(500, 35, 1, 0);
        drive(0);
        for (int i = 37; i < 43; i++) drive(0);

        // ts 43..68: pile-up
        for (int i = 0; i < 25; i++) drive(150);
        push_exp(150, 43, 25, 1);
        drive(0);
        for (int i = 69; i < 75; i++) drive(0);

        // ts 75..84: back-pressure
        peak_ready = 1'b0;
        drive(0);
        drive(300);
        push_exp(300, 76, 1, 0);
        drive(0);
        for (int i = 78; i < 82; i++) drive(0);
        drive(400);
        check("overflow_before_drop", overflow, 0);
        drive(0);
        check("overflow_set",   overflow, 1);
        check("overflow_set4",  overflow4, 1);
        check("bp_valid_held",  peak_valid, 1);
        check("bp_amp_kept",    peak_amp, 300);
        check("bp_time_kept",   peak_time, 76);
        peak_ready = 1'b1;
        drive(0);
        check("bp_valid_cleared", peak_valid, 0);
        check("overflow_sticky",  overflow, 1);
        for (int i = 0; i < 4; i++) drive(0);

        // reset mid-RISE
        drive(200);
        drive(300);
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid",    peak_valid, 0);
        check("rst_amp",      peak_amp, 0);
        check("rst_time",     peak_time, 0);
        check("rst_width",    peak_width, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy",     busy, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(50);
        check("busy_after_50", busy, 0);
        drive(200);
        push_exp(200, 1, 1, 0);
        drive(0);
        for (int i = 0; i < 8; i++) drive(0);

        check("queue_drained",     q8.size(), 0);
        check("queue_drained_pw4", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
